// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
// Holds the transaction state encoding and the address range helper.
package ram_arb_pkg;

    localparam int NUM_PORTS = 2;
    localparam int DATA_W    = 16;
    localparam int ADDR_W    = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_e;

    // Full-width unsigned compare; addresses never wrap into the RAM.
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                           input int unsigned       mem_size);
        return 32'(addr) < mem_size;
    endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-requester round-robin grant logic; purely combinational.
// The caller owns the priority pointer and decides when it advances.
module rr_arbiter_2
    import ram_arb_pkg::*;
(
    input  logic [NUM_PORTS-1:0] i_req,
    input  logic                 i_ptr,
    output logic [NUM_PORTS-1:0] o_grant
);

    // A port wins when it is alone, or when both ask and it holds priority.
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_grant
        assign o_grant[gi] = i_req[gi] & (~i_req[NUM_PORTS-1-gi] | (i_ptr == 1'(gi)));
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares a single-port, 1-cycle-latency RAM between a CPU port and a DMA port.
// One transaction in flight: grant (IDLE) -> RAM access (ACCESS) -> response (RESP).
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned MEMORY_SIZE = 512
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ack,
    output logic              p0_rsp_valid,
    output logic [DATA_W-1:0] p0_rsp_data,
    output logic              p0_err,

    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic              p1_rsp_valid,
    output logic [DATA_W-1:0] p1_rsp_data,
    output logic              p1_err,

    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_rdata,

    output logic              busy
);

    arb_state_e r_state;
    arb_state_e w_state_next;

    logic                 r_ptr;
    logic                 r_port;
    logic                 r_we;
    logic                 r_err;
    logic                 r_ram_we;
    logic [ADDR_W-1:0]    r_ram_addr;
    logic [DATA_W-1:0]    r_ram_wdata;

    logic [NUM_PORTS-1:0] w_req;
    logic [NUM_PORTS-1:0] w_grant;
    logic                 w_take;
    logic                 w_sel_we;
    logic [ADDR_W-1:0]    w_sel_addr;
    logic [DATA_W-1:0]    w_sel_wdata;
    logic                 w_in_range;

    logic [NUM_PORTS-1:0] w_ack;
    logic [NUM_PORTS-1:0] w_rsp_valid;
    logic [DATA_W-1:0]    w_rsp_data;
    logic                 w_rsp_err;
    logic [DATA_W-1:0]    w_port_data [NUM_PORTS];
    logic [NUM_PORTS-1:0] w_port_err;

    assign w_req = {p1_req, p0_req};

    rr_arbiter_2 u_rr (
        .i_req   (w_req),
        .i_ptr   (r_ptr),
        .o_grant (w_grant)
    );

    assign w_take      = (r_state == IDLE) && (|w_req);
    assign w_sel_we    = w_grant[1] ? p1_we    : p0_we;
    assign w_sel_addr  = w_grant[1] ? p1_addr  : p0_addr;
    assign w_sel_wdata = w_grant[1] ? p1_wdata : p0_wdata;
    assign w_in_range  = addr_in_range(w_sel_addr, MEMORY_SIZE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (|w_req) w_state_next = ACCESS;
            ACCESS:  w_state_next = RESP;
            RESP:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Acks and responses are suppressed while reset is high so an aborted
    // transaction never reports back.
    always_comb begin
        w_ack       = '0;
        w_rsp_valid = '0;
        w_rsp_data  = '0;
        w_rsp_err   = 1'b0;
        if (!reset) begin
            case (r_state)
                IDLE: w_ack = w_grant;
                RESP: begin
                    w_rsp_valid[r_port] = 1'b1;
                    w_rsp_data          = (r_err || r_we) ? '0 : ram_rdata;
                    w_rsp_err           = r_err;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr       <= 1'b0;
            r_port      <= 1'b0;
            r_we        <= 1'b0;
            r_err       <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
        end else if (w_take) begin
            // Pointer moves to whichever port did not win this grant.
            r_ptr       <= w_grant[0];
            r_port      <= w_grant[1];
            r_we        <= w_sel_we;
            r_err       <= ~w_in_range;
            r_ram_we    <= w_sel_we & w_in_range;
            r_ram_addr  <= w_in_range ? w_sel_addr  : '0;
            r_ram_wdata <= w_in_range ? w_sel_wdata : '0;
        end else if (r_state == ACCESS) begin
            r_ram_we    <= 1'b0;
        end
    end

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_rsp
        assign w_port_data[gi] = w_rsp_valid[gi] ? w_rsp_data : '0;
        assign w_port_err[gi]  = w_rsp_valid[gi] & w_rsp_err;
    end

    assign p0_ack       = w_ack[0];
    assign p0_rsp_valid = w_rsp_valid[0];
    assign p0_rsp_data  = w_port_data[0];
    assign p0_err       = w_port_err[0];

    assign p1_ack       = w_ack[1];
    assign p1_rsp_valid = w_rsp_valid[1];
    assign p1_rsp_data  = w_port_data[1];
    assign p1_err       = w_port_err[1];

    assign ram_we    = r_ram_we;
    assign ram_addr  = r_ram_addr;
    assign ram_wdata = r_ram_wdata;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Randomised and directed bench for ram_port_arbiter with an attached RAM.
// A transaction-level model predicts grants and responses; a monitor pops them.
module tb_ram_port_arbiter;

    localparam int MEM = 512;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        p0_req = 1'b0, p0_we = 1'b0;
    logic [15:0] p0_addr = '0, p0_wdata = '0;
    logic        p0_ack, p0_rsp_valid, p0_err;
    logic [15:0] p0_rsp_data;
    logic        p1_req = 1'b0, p1_we = 1'b0;
    logic [15:0] p1_addr = '0, p1_wdata = '0;
    logic        p1_ack, p1_rsp_valid, p1_err;
    logic [15:0] p1_rsp_data;
    logic        ram_we, busy;
    logic [15:0] ram_wdata, ram_addr;
    logic [15:0] ram_rdata;

    ram_port_arbiter #(.MEMORY_SIZE(MEM)) dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(p0_ack), .p0_rsp_valid(p0_rsp_valid), .p0_rsp_data(p0_rsp_data), .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_rsp_valid(p1_rsp_valid), .p1_rsp_data(p1_rsp_data), .p1_err(p1_err),
        .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_addr(ram_addr), .ram_rdata(ram_rdata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Attached single-port RAM with one cycle of read latency.
    logic [15:0] ram_mem [0:MEM-1];
    always @(posedge clk) begin
        if (ram_we && ram_addr < 16'(MEM)) ram_mem[ram_addr[8:0]] <= ram_wdata;
        ram_rdata <= (ram_addr < 16'(MEM)) ? ram_mem[ram_addr[8:0]] : 16'h0;
    end

    typedef struct {
        int          due;
        int          port;
        logic [15:0] data;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] ref_mem [0:MEM-1];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Transaction-level model: phase 0 idle, 1 RAM access, 2 response.
    int          m_phase = 0;
    int          m_ptr = 0;
    bit          m_we = 1'b0;
    logic [15:0] m_addr = '0, m_wdata = '0;
    bit          m_just_reset = 1'b1;

    always @(negedge clk) begin : model_blk
        int   win;
        bit   inr;
        exp_t e;
        if (mon_en) begin
            win = -1;
            if (m_phase == 0 && !reset && (p0_req || p1_req))
                win = (p0_req && p1_req) ? m_ptr : (p1_req ? 1 : 0);
            check("ack", 32'({p1_ack, p0_ack}), (win == 0) ? 32'd1 : (win == 1) ? 32'd2 : 32'd0);
            check("busy", 32'(busy), 32'(m_phase != 0));
            inr = (m_addr < 16'(MEM));
            check("ram_we", 32'(ram_we), 32'(m_phase == 1 && m_we && inr));
            if (m_phase == 1) begin
                check("ram_addr", 32'(ram_addr), inr ? 32'(m_addr) : 32'd0);
                if (m_we && inr) check("ram_wdata", 32'(ram_wdata), 32'(m_wdata));
            end
            if (m_just_reset) begin
                check("rst_ram_addr", 32'(ram_addr), 32'd0);
                check("rst_ram_wdata", 32'(ram_wdata), 32'd0);
                m_just_reset = 1'b0;
            end
            if (reset) begin
                m_phase = 0;
                m_ptr = 0;
                m_just_reset = 1'b1;
            end else if (win >= 0) begin
                m_we    = (win == 1) ? p1_we : p0_we;
                m_addr  = (win == 1) ? p1_addr : p0_addr;
                m_wdata = (win == 1) ? p1_wdata : p0_wdata;
                e.due  = cyc + 2;
                e.port = win;
                e.err  = !(m_addr < 16'(MEM));
                e.data = 16'h0;
                if (!e.err) begin
                    if (m_we) ref_mem[m_addr[8:0]] = m_wdata;
                    else      e.data = ref_mem[m_addr[8:0]];
                end
                exp_q.push_back(e);
                m_ptr = 1 - win;
                m_phase = 1;
            end else if (m_phase == 1) begin
                m_phase = 2;
            end else if (m_phase == 2) begin
                m_phase = 0;
            end
        end
    end

    // Response monitor: pops the scoreboard whenever a port presents rsp_valid.
    always @(negedge clk) begin : rsp_mon
        exp_t e;
        if (mon_en) begin
            if (reset) begin
                check("rsp_during_reset", 32'({p1_rsp_valid, p0_rsp_valid}), 32'd0);
                exp_q.delete();
            end else begin
                if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_missing port %0d: got none expected at cycle %0d", exp_q[0].port, exp_q[0].due);
                    exp_q.delete(0);
                end
                if (p0_rsp_valid || p1_rsp_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rsp_unexpected cycle %0d: got valid %b%b expected none", cyc, p1_rsp_valid, p0_rsp_valid);
                    end else begin
                        e = exp_q.pop_front();
                        check("rsp_port", 32'({p1_rsp_valid, p0_rsp_valid}), (e.port == 1) ? 32'd2 : 32'd1);
                        check("rsp_cycle", 32'(cyc), 32'(e.due));
                        check("rsp_data", 32'((e.port == 1) ? p1_rsp_data : p0_rsp_data), 32'(e.data));
                        check("rsp_err", 32'((e.port == 1) ? p1_err : p0_err), 32'(e.err));
                    end
                end
            end
            if (!p0_rsp_valid) check("p0_idle_rsp", 32'({p0_err, p0_rsp_data}), 32'd0);
            if (!p1_rsp_valid) check("p1_idle_rsp", 32'({p1_err, p1_rsp_data}), 32'd0);
        end
    end

    // A request must be held until it is acknowledged.
    bit pend0 = 1'b0, pend1 = 1'b0;
    always @(negedge clk) begin
        assert (!(pend0 && !p0_req)) else begin
            errors++;
            $display("FAIL proto p0: got req dropped expected held until ack");
        end
        assert (!(pend1 && !p1_req)) else begin
            errors++;
            $display("FAIL proto p1: got req dropped expected held until ack");
        end
        pend0 = p0_req && !p0_ack && !reset;
        pend1 = p1_req && !p1_ack && !reset;
    end

    // Caller is #1 after a posedge; returns #1 after the posedge ending the ack cycle.
    task automatic drive(input int p, input bit we, input logic [15:0] addr, input logic [15:0] wd);
        int n = 0;
        bit got = 1'b0;
        if (p == 0) begin p0_req = 1'b1; p0_we = we; p0_addr = addr; p0_wdata = wd; end
        else        begin p1_req = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wd; end
        while (!got && n < 100) begin
            @(negedge clk);
            got = (p == 0) ? p0_ack : p1_ack;
            n++;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout port %0d: got no ack expected one within 100 cycles", p);
        end else begin
            $display("txn port %0d %s addr %h wdata %h ack cycle %0d", p, we ? "WR" : "RD", addr, wd, cyc);
        end
        @(posedge clk);
        #1;
        if (p == 0) p0_req = 1'b0; else p1_req = 1'b0;
    endtask

    task automatic rand_port(input int p, input int n);
        for (int i = 0; i < n; i++) begin
            int          gap;
            int          sel;
            logic [15:0] addr;
            gap = $urandom_range(0, 3);
            repeat (gap) begin @(posedge clk); #1; end
            sel = $urandom_range(0, 9);
            if (sel == 0)      addr = 16'($urandom_range(512, 65535));
            else if (sel == 1) addr = 16'($urandom_range(511, 512));
            else               addr = 16'($urandom_range(0, 15));
            drive(p, 1'($urandom_range(0, 1)), addr, 16'($urandom));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected end of test");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < MEM; i++) begin
            ram_mem[i] = 16'h0;
            ref_mem[i] = 16'h0;
        end
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        mon_en = 1'b1;

        // Both ports contend from reset: p0, p1, p0, p1.
        fork
            begin drive(0, 1'b1, 16'd10, 16'h1111); drive(0, 1'b0, 16'd10, 16'h0); end
            begin drive(1, 1'b1, 16'd11, 16'h2222); drive(1, 1'b0, 16'd11, 16'h0); end
        join

        drive(0, 1'b1, 16'd5, 16'hBEEF);
        drive(0, 1'b0, 16'd5, 16'h0);

        drive(1, 1'b0, 16'd10, 16'h0);
        drive(1, 1'b0, 16'd11, 16'h0);
        drive(1, 1'b0, 16'd5, 16'h0);
        drive(1, 1'b0, 16'd0, 16'h0);

        drive(0, 1'b1, 16'd512, 16'hDEAD);
        drive(0, 1'b0, 16'hFFFF, 16'h0);

        // Reset in the RESP cycle of a p1 read.
        drive(1, 1'b0, 16'd5, 16'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        fork
            drive(0, 1'b0, 16'd10, 16'h0);
            drive(1, 1'b0, 16'd11, 16'h0);
        join

        // Reset coinciding with the ACCESS cycle of a p0 write.
        drive(0, 1'b1, 16'd7, 16'h0707);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        fork
            drive(0, 1'b0, 16'd7, 16'h0);
            drive(1, 1'b0, 16'd10, 16'h0);
        join

        fork
            rand_port(0, 40);
            rand_port(1, 40);
        join

        repeat (6) begin @(posedge clk); #1; end
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
Shares the single-port, 1-cycle-read-latency data RAM between two requesters: port 0 (CPU load/store unit) and port 1 (DMA/program loader). Sits directly in front of the RAM and owns its write_enabled, write_value and address inputs. Requesters use a req/ack handshake and receive an rsp_valid pulse with read data or a range error. Arbitration is round-robin with one transaction in flight.

Parameters:
MEMORY_SIZE, 512, number of 16-bit words in the attached RAM; addresses >= MEMORY_SIZE are out of range.

Ports:
clk  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-high reset
p0_req  in  1  port 0 request; held with fields stable until p0_ack
p0_we  in  1  port 0 write (1) / read (0)
p0_addr  in  16  port 0 word address
p0_wdata  in  16  port 0 write data
p0_ack  out  1  port 0 request accepted (combinational, 1-cycle pulse)
p0_rsp_valid  out  1  port 0 response pulse
p0_rsp_data  out  16  port 0 read data, valid with p0_rsp_valid
p0_err  out  1  port 0 out-of-range flag, valid with p0_rsp_valid
p1_req, p1_we, p1_addr, p1_wdata, p1_ack, p1_rsp_valid, p1_rsp_data, p1_err: same as port 0, for port 1
ram_we  out  1  to RAM write_enabled (registered)
ram_wdata  out  16  to RAM write_value (registered)
ram_addr  out  16  to RAM address (registered)
ram_rdata  in  16  from RAM memory_out
busy  out  1  high whenever state != IDLE

Behaviour:
- Clocking: single clock clk; reset synchronous, active-high.
- States: IDLE, ACCESS, RESP.
- IDLE: if any req, pick winner, assert its ack combinationally this cycle, latch port id, we, addr, wdata; next state ACCESS. No req: stay IDLE.
- Round-robin: priority pointer starts at port 0 after reset. Both requesting: the pointed-to port wins. After every grant the pointer moves to the non-granted port. Single requester always wins regardless of pointer.
- On grant, in-range (addr < MEMORY_SIZE): ram_addr <= addr, ram_wdata <= wdata, ram_we <= we, registered into ACCESS.
- On grant, out-of-range: ram_we <= 0, ram_addr <= 0, error flag latched; RAM is not written.
- ACCESS: RAM samples ram_* at the end of this cycle; ram_we <= 0 on exit. Next state RESP.
- RESP: the granted port's rsp_valid = 1 for exactly one cycle.
  - In-range read: rsp_data = ram_rdata, err = 0.
  - Write: rsp_data = 0, err = 0.
  - Out of range: rsp_data = 0, err = 1.
  - Next state IDLE.
- Latency: ack in cycle N, ram_we/ram_addr visible in N+1, rsp_valid in N+2. Earliest next ack is N+3, so the maximum rate is 1 transaction per 3 cycles.
- ack and rsp outputs are 0 for the non-granted port and in all non-qualifying states. acks are 0 while reset is high.
- Reset values: state IDLE, pointer port 0, ram_we 0, ram_addr 0, ram_wdata 0, all rsp_valid/err 0, rsp_data 0, busy 0.
- Reset mid-operation: the transaction is abandoned and no rsp is issued. A write whose ACCESS cycle coincides with reset still commits, because the RAM samples ram_we at that same edge.
- A req deasserted before ack is a protocol violation; the behaviour is undefined and flagged by a bench assertion.
- Address compare is full 16-bit unsigned; there is no wrap-around.

Decomposition:
- Shared package ram_arb_pkg: state enum (IDLE/ACCESS/RESP), NUM_PORTS=2, DATA_W=16, ADDR_W=16.
- Sub-module rr_arbiter_2: inputs req[1:0] and pointer; outputs one-hot grant[1:0]. Pointer update stays in the parent.

Test Plan:
- Single write then read, p0: write addr 5 = 16'hBEEF, then read addr 5 -> ack at N, ram_we=1/ram_addr=5 at N+1, rsp_valid at N+2; read returns 16'hBEEF, err=0.
- Contention: p0 and p1 both request continuously from reset, p0 write addr 10 = 16'h1111, p1 write addr 11 = 16'h2222 -> grant order p0, p1, p0, p1, 3 cycles apart. Subsequent reads of addr 10/11 return 1111/2222.
- Lone requester: only p1 requests 4 reads back-to-back -> 4 grants to p1 every 3 cycles; no acks or rsps on p0.
- Out of range (MEMORY_SIZE=512): p0 write addr 512 = 16'hDEAD -> rsp_valid with err=1, ram_we never high. p0 read addr 16'hFFFF -> err=1, data=0.
- Reset mid-op: reset asserted in the RESP cycle of a p1 read -> no p1_rsp_valid. Next cycle all outputs are at reset values, and the pointer is back at p0 (simultaneous requests go to p0).
- Write/reset coincidence: reset asserted in the ACCESS cycle of a write to addr 7 = 16'h0707 -> after reset, a read of addr 7 returns 16'h0707.
